alu_seq_ctrl: RTL

- Multi-cycle sequencer that owns the 8x16 register file and the shared 16-bit ALU.
- Accepts one decoded command at a time over a valid/ready handshake.
- Sequences operand read, ALU execute and register writeback, then reports branch and overflow status to the fetch/PC logic.
- Sits between the decoder and the regfile/ALU pair.

---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/alu_seq_ctrl_if.sv | 27 ++
 rtl/TwoToOneMux.sv | 12 +
 rtl/alu_seq_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer, the ALU and the regfile.
//   alu_op_e      : ALU select codes 0-8; codes 9-15 are undefined.
//   ctrl_state_e  : sequencer FSM states.
//   op_writes_rd  : 1 when an op commits its result to rd.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_NOTB = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ASR  = 4'd4,
    OP_LSL  = 4'd5,
    OP_BEQZ = 4'd6,
    OP_BNEZ = 4'd7,
    OP_XOR  = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} ctrl_state_e;

  // Branches and undefined codes never write the regfile.
  function automatic logic op_writes_rd(input logic [3:0] op);
    case (op)
      OP_ADD, OP_NOTB, OP_AND, OP_OR, OP_ASR, OP_LSL, OP_XOR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Decoder -> sequencer command handshake.
//   master (decoder)  : drives cmd_valid and command fields, samples cmd_ready.
//   slave (sequencer) : samples command, drives cmd_ready.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic              cmd_use_imm;
  logic [DATA_W-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/TwoToOneMux.sv
// Generic 2:1 mux.
//   a_i/b_i : data inputs, sel_i : 1 selects b_i, y_o : result.
module TwoToOneMux #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer owning the 8x16 regfile and shared ALU.
// One command per 4 cycles: IDLE (accept) -> OPRD -> EXEC -> WB.
//   clk, rst            : clock, async active-low reset
//   cmd (slave)         : decoded command handshake
//   rf_rd0/1_*          : regfile read ports (combinational data)
//   rf_wr_*             : regfile write port, active in WB
//   alu_a/b/s, alu_f... : shared ALU operands/select and result/flags
//   done, done_*        : writeback pulse and per-op status to fetch/PC
//   ovf_sticky, ovf_clr : accumulated add overflow and its clear
//   busy                : command in flight
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_ctrl_if.slave     cmd,
  output logic [ADDR_W-1:0] rf_rd0_addr,
  output logic [ADDR_W-1:0] rf_rd1_addr,
  input  logic [DATA_W-1:0] rf_rd0_data,
  input  logic [DATA_W-1:0] rf_rd1_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_take_branch,
  input  logic              alu_ovf,
  output logic              done,
  output logic              done_take_branch,
  output logic              done_ovf,
  output logic              ovf_sticky,
  input  logic              ovf_clr,
  output logic              busy
);

  ctrl_state_e state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic              use_imm_q;
  logic [DATA_W-1:0] imm_q, opa_q, opb_q, res_q, opb_mux;
  logic              br_q, ovf_q, sticky_q;
  logic              accept;

  assign accept = cmd.cmd_valid && (state_q == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = OPRD;
      OPRD:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd.cmd_ready    = (state_q == IDLE);
    busy             = (state_q != IDLE);
    done             = (state_q == WB);
    rf_wr_en         = done && op_writes_rd(op_q);
    done_take_branch = done && br_q;
    // Only add reports overflow; other ops' ALU ovf is meaningless.
    done_ovf         = done && ovf_q && (op_q == OP_ADD);
  end

  TwoToOneMux #(.W(DATA_W)) u_opb_mux (
    .a_i   (rf_rd1_data),
    .b_i   (imm_q),
    .sel_i (use_imm_q),
    .y_o   (opb_mux)
  );

  // Command, operand and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      br_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= cmd.cmd_op;
        rd_q      <= cmd.cmd_rd;
        rs1_q     <= cmd.cmd_rs1;
        rs2_q     <= cmd.cmd_rs2;
        use_imm_q <= cmd.cmd_use_imm;
        imm_q     <= cmd.cmd_imm;
      end
      if (state_q == OPRD) begin
        opa_q <= rf_rd0_data;
        opb_q <= opb_mux;
      end
      if (state_q == EXEC) begin
        res_q <= alu_f;
        br_q  <= alu_take_branch;
        ovf_q <= alu_ovf;
      end
    end
  end

  // Sticky overflow: a set in WB beats a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            sticky_q <= 1'b0;
    else if ((state_q == WB) && (op_q == OP_ADD) && ovf_q) sticky_q <= 1'b1;
    else if (ovf_clr)                                    sticky_q <= 1'b0;
  end

  assign rf_rd0_addr = rs1_q;
  assign rf_rd1_addr = rs2_q;
  assign rf_wr_addr  = rd_q;
  assign rf_wr_data  = res_q;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_s       = op_q;
  assign ovf_sticky  = sticky_q;

endmodule
